// File: rtl/udma_evt_pkg.sv
// udma_evt_pkg: shared widths and types for the uDMA event queue.
//   EVT_ID_W   - width of an event ID pushed into the output FIFO
//   LOST_CNT_W - width of the saturating dropped-event counter
package udma_evt_pkg;
  localparam int EVT_ID_W   = 8;
  localparam int LOST_CNT_W = 8;
  typedef logic [EVT_ID_W-1:0] evt_id_t;
  typedef logic [LOST_CNT_W-1:0] lost_cnt_t;
endpackage

// File: rtl/udma_evt_rr_arb.sv
// udma_evt_rr_arb: N-input round-robin arbiter with one-hot grant.
//   clk_i, rstn_i - clock, async active-low reset
//   clr_i         - synchronous return of priority to index 0
//   req           - request vector (one bit per source)
//   gnt_en        - grant permitted this cycle
//   gnt           - one-hot grant, zero when nothing granted
//   gnt_vld       - a grant is issued this cycle
//   gnt_idx       - index of the granted source
module udma_evt_rr_arb #(
  parameter int N  = 32,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clr_i,
  input  logic [N-1:0]  req,
  input  logic          gnt_en,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          any;
  int            j;

  // Scan from the current priority index upward, wrapping; first requester wins.
  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt_vld = gnt_en & any;
    gnt     = gnt_vld ? (N'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      ptr <= '0;
    else if (clr_i)   ptr <= '0;
    else if (gnt_vld) ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/udma_evt_queue.sv
// udma_evt_queue: collects per-source event pulses into pending bits and
// queues their IDs, round-robin, into a small FIFO for a single consumer.
//   clk_i, rstn_i  - clock, async active-low reset
//   clr_i          - synchronous flush of pending bits, FIFO, priority, lost count
//   evt_i          - one-cycle event pulses, one bit per source
//   event_valid_o  - FIFO head valid
//   event_data_o   - event ID at FIFO head (0 when empty)
//   event_ready_i  - consumer accepts head
//   lost_o         - pulse one cycle after any cycle that dropped an event
//   lost_cnt_o     - saturating count of cycles that dropped events
module udma_evt_queue
  import udma_evt_pkg::*;
#(
  parameter int N_EVT     = 32,
  parameter int DEPTH     = 4,
  parameter int ID_OFFSET = 0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic [N_EVT-1:0]      evt_i,
  output logic                  event_valid_o,
  output logic [EVT_ID_W-1:0]   event_data_o,
  input  logic                  event_ready_i,
  output logic                  lost_o,
  output logic [LOST_CNT_W-1:0] lost_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (N_EVT > 1) ? $clog2(N_EVT) : 1;

  logic [N_EVT-1:0] pending, gnt, drop;
  logic             gnt_vld, gnt_en;
  logic [IW-1:0]    gnt_idx;
  evt_id_t          mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             empty, full, push, pop;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = ~empty & event_ready_i & ~clr_i;
  // A full FIFO still accepts a push on the cycle its head is popped.
  assign gnt_en = ~clr_i & (~full | pop);
  assign push   = gnt_vld;
  // An event arriving on an already-pending source is lost unless that
  // source is being granted, in which case the new event re-arms pending.
  assign drop   = evt_i & pending & ~gnt;

  assign event_valid_o = ~empty;
  assign event_data_o  = empty ? '0 : mem[rptr[AW-1:0]];

  udma_evt_rr_arb #(.N(N_EVT), .IW(IW)) u_arb (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (clr_i),
    .req     (pending),
    .gnt_en  (gnt_en),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending    <= '0;
      wptr       <= '0;
      rptr       <= '0;
      lost_o     <= 1'b0;
      lost_cnt_o <= '0;
    end else if (clr_i) begin
      pending    <= '0;
      wptr       <= '0;
      rptr       <= '0;
      lost_o     <= 1'b0;
      lost_cnt_o <= '0;
    end else begin
      pending <= (pending & ~gnt) | evt_i;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      lost_o <= |drop;
      if (|drop && lost_cnt_o != '1) lost_cnt_o <= lost_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= evt_id_t'(32'(gnt_idx) + ID_OFFSET);
  end
endmodule
